bus_responder: RTL and testbench
================================

# bus_responder

Memory/I-O responder for the 6502 core's bus. Serves the core's `address`/`o_data`/`wren` requests and returns registered `i_data` with one-clock read latency. Holds the core in reset while a loader FSM streams a ROM image into the upper half of memory. Provides write-protected ROM, 32 KiB RAM and a small I/O page with a tick counter and parallel ports.

## Interface
- `ROM_BASE`, default 16'h8000: first ROM address; also the loader start address.
- `IO_PAGE`, default 8'h7F: high address byte of the I/O page (16'h7F00–16'h7FFF).
- `LOAD_EN`, default 1: 1 = leave reset in LOAD; 0 = leave reset directly in RUN.
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_addr` in 16: bus address from the core.
- `cpu_wdata` in 8: write data from the core.
- `cpu_wren` in 1: write strobe from the core.
- `cpu_rdata` out 8: registered read data to the core.
- `cpu_hold` out 1: drives the core's reset; 1 while in LOAD.
- `load_valid` in 1: loader byte valid.
- `load_data` in 8: loader byte.
- `load_last` in 1: marks the final loader byte; qualified by `load_valid`.
- `load_ready` out 1: loader can accept a byte; 1 only in LOAD.
- `io_in` in 8: external input port.
- `io_out` out 8: external output port register.

## Operation
- Storage: 64 KiB byte array; contents are not cleared by reset.
- FSM states are LOAD and RUN.
- Reset:
  - State goes to LOAD if `LOAD_EN`=1, else RUN.
  - `load_ptr` = `ROM_BASE`, tick = 0, shadow = 0, `io_out` = 0, `cpu_rdata` = 0.
  - `cpu_hold` = 1 if `LOAD_EN`, else 0.
- LOAD:
  - `load_ready`=1 and `cpu_hold`=1.
  - A byte is accepted when `load_valid & load_ready`: mem[`load_ptr`] is written with `load_data`, then `load_ptr`+1.
  - Go to RUN after accepting a byte with `load_last`=1, or after the byte written at 16'hFFFF (full).
  - The loader ignores ROM protection.
  - CPU writes are ignored; CPU reads still operate.
- RUN:
  - `load_ready`=0 and `cpu_hold`=0; `load_valid` is ignored.
  - Only reset returns the FSM to LOAD.
- CPU address decode, with the same rules for reads and writes:
  - I/O page (`cpu_addr[15:8]`==`IO_PAGE`) is not backed by RAM; writes to it never reach the array.
  - ROM (`cpu_addr` >= `ROM_BASE`): reads from the array; CPU writes are dropped silently.
  - Otherwise RAM: read/write.
- I/O registers (offset = `cpu_addr[7:0]`):
  - 00: tick[7:0] on read; a read latches tick[15:8] into the shadow register; a write clears tick to 0.
  - 01: shadow on read; writes ignored.
  - 02: `io_out` on read; a write loads `io_out`.
  - 03: `io_in` sampled on read; writes ignored.
  - Other offsets: read 8'h00; writes ignored.
- Tick counter:
  - 16-bit; increments by 1 per clock in RUN and holds in LOAD.
  - Wraps 16'hFFFF→0.
  - Clear-by-write wins over increment in the same cycle.
- Reads happen every cycle regardless of `cpu_wren`; there is no read strobe.

## Timing
- Read latency is 1 clock: `cpu_addr` sampled at edge N gives `cpu_rdata` valid after edge N.
- Read-during-write to the same RAM address returns the old byte; the new byte is visible from the next read.
- `io_out` updates at the edge that samples the write.
- Tick read at 00 returns the counter value before that edge's increment; the shadow gets the high byte of the same value.
- `cpu_hold` and `load_ready` are registered from state.
  - They fall in the cycle after the edge that accepts the last or full byte.
  - They rise in the cycle after a reset edge.
- Reset mid-load: the next edge restarts at `ROM_BASE`; bytes already written stay in memory.

## Test plan
- Load: reset, then stream A9,01,8D,02 with `load_last` on the 4th byte → mem[8000..8003]=A9,01,8D,02; `cpu_hold`/`load_ready` fall one cycle after the 4th accept; a further `load_valid` writes nothing.
- RAM:
  - Write 55 to 0010 → read of 0010 one cycle later returns 55.
  - Write AA to 0010 while reading 0010 → `cpu_rdata`=55; the next read gives AA.
- ROM protection: in RUN write 12 to 8000 → a read of 8000 still returns A9.
- I/O ports:
  - Write 3C to 7F02 → `io_out`=3C after that edge, and a read of 7F02 returns 3C.
  - With `io_in`=99, a read of 7F03 returns 99.
  - A read of 7F10 returns 00; mem[7F02] is unchanged.
- Tick counter:
  - Write 7F00 to clear, then read 7F00 when tick=00FF → 0xFF.
  - Read 7F01 three cycles later → 0x00 (shadow, not the live 0x01).
  - Counter holds in LOAD and wraps FFFF→0000.
- Loader boundaries:
  - Reset after 2 bytes → the pointer restarts at 8000.
  - Stream 32768 bytes without `load_last` → RUN entered after the byte at FFFF.
  - `LOAD_EN`=0 → `cpu_hold`=0 immediately after reset.

Source files
------------

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - 6502 bus responder: boot loader, protected ROM, RAM, I/O page with tick counter
module bus_responder #(
  parameter logic [15:0] ROM_BASE = 16'h8000,
  parameter logic [7:0]  IO_PAGE  = 8'h7F,
  parameter bit          LOAD_EN  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_wren,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_hold,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  input  logic        load_last,
  output logic        load_ready,
  input  logic [7:0]  io_in,
  output logic [7:0]  io_out
);

  typedef enum logic {LOAD, RUN} state_t;

  state_t      state;
  logic [7:0]  mem [0:65535];
  logic [15:0] load_ptr;
  logic [15:0] tick;
  logic [7:0]  shadow;

  logic        io_sel;
  logic        rom_sel;
  logic [7:0]  io_off;
  logic        load_fire;
  logic        cpu_we;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  io_rdata;

  always_comb begin
    io_sel    = (cpu_addr[15:8] == IO_PAGE);
    rom_sel   = (cpu_addr >= ROM_BASE);
    io_off    = cpu_addr[7:0];
    load_fire = (state == LOAD) && load_valid;
    // CPU writes only take effect once the core is running
    cpu_we    = (state == RUN) && cpu_wren;
    mem_we    = !reset && (load_fire || (cpu_we && !io_sel && !rom_sel));
    mem_addr  = load_fire ? load_ptr : cpu_addr;
    mem_wdata = load_fire ? load_data : cpu_wdata;
  end

  always_comb begin
    io_rdata = 8'h00;
    case (io_off)
      8'h00:   io_rdata = tick[7:0];
      8'h01:   io_rdata = shadow;
      8'h02:   io_rdata = io_out;
      8'h03:   io_rdata = io_in;
      default: io_rdata = 8'h00;
    endcase
  end

  // Storage has no reset so it can map onto block RAM
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_rdata <= 8'h00;
    end else begin
      cpu_rdata <= io_sel ? io_rdata : mem[cpu_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= LOAD_EN ? LOAD : RUN;
      load_ptr   <= ROM_BASE;
      cpu_hold   <= LOAD_EN;
      load_ready <= LOAD_EN;
    end else if (load_fire) begin
      load_ptr <= load_ptr + 16'd1;
      if (load_last || (load_ptr == 16'hFFFF)) begin
        state      <= RUN;
        cpu_hold   <= 1'b0;
        load_ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tick   <= 16'h0000;
      shadow <= 8'h00;
      io_out <= 8'h00;
    end else begin
      // Reading the low byte freezes the high byte for a coherent 16-bit read
      if (io_sel && (io_off == 8'h00)) begin
        shadow <= tick[15:8];
      end
      if (cpu_we && io_sel && (io_off == 8'h00)) begin
        tick <= 16'h0000;
      end else if (state == RUN) begin
        tick <= tick + 16'd1;
      end
      if (cpu_we && io_sel && (io_off == 8'h02)) begin
        io_out <= cpu_wdata;
      end
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - self-checking bench for bus_responder
module tb_bus_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wren;
  logic [7:0]  cpu_rdata;
  logic        cpu_hold;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic [7:0]  io_in;
  logic [7:0]  io_out;

  logic        b_reset;
  logic [15:0] b_addr;
  logic [7:0]  b_rdata;
  logic        b_hold;
  logic        b_ready;
  logic [7:0]  b_io_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  bus_responder dut (
    .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wren(cpu_wren), .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .io_in(io_in), .io_out(io_out)
  );

  bus_responder #(.LOAD_EN(1'b0)) dut_run (
    .clock(clock), .reset(b_reset), .cpu_addr(b_addr), .cpu_wdata(8'h00),
    .cpu_wren(1'b0), .cpu_rdata(b_rdata), .cpu_hold(b_hold),
    .load_valid(1'b0), .load_data(8'h00), .load_last(1'b0),
    .load_ready(b_ready), .io_in(8'h00), .io_out(b_io_out)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the main instance
  logic [7:0]  m_mem [0:65535];
  bit          m_known [0:65535];
  bit          m_valid = 1'b0;
  bit          m_load;
  logic [15:0] m_ptr;
  logic [15:0] m_tick;
  logic [7:0]  m_shadow;
  logic [7:0]  m_io_out;
  logic [7:0]  m_rdata;
  bit          m_rknown;

  always @(posedge clock) begin
    logic [15:0] tick_next;
    logic [7:0]  shadow_next;
    if (reset) begin
      m_load = 1'b1; m_ptr = 16'h8000; m_tick = 16'h0; m_shadow = 8'h0;
      m_io_out = 8'h0; m_rdata = 8'h0; m_rknown = 1'b1; m_valid = 1'b1;
    end else if (m_valid) begin
      if (cpu_addr[15:8] == 8'h7F) begin
        m_rknown = 1'b1;
        case (cpu_addr[7:0])
          8'h00:   m_rdata = m_tick[7:0];
          8'h01:   m_rdata = m_shadow;
          8'h02:   m_rdata = m_io_out;
          8'h03:   m_rdata = io_in;
          default: m_rdata = 8'h00;
        endcase
      end else begin
        m_rdata  = m_mem[cpu_addr];
        m_rknown = m_known[cpu_addr];
      end
      shadow_next = (cpu_addr == 16'h7F00) ? m_tick[15:8] : m_shadow;
      tick_next   = m_load ? m_tick : m_tick + 16'd1;
      if (!m_load && cpu_wren) begin
        if (cpu_addr == 16'h7F00) tick_next = 16'h0;
        else if (cpu_addr == 16'h7F02) m_io_out = cpu_wdata;
        else if (cpu_addr[15:8] != 8'h7F && cpu_addr < 16'h8000) begin
          m_mem[cpu_addr] = cpu_wdata; m_known[cpu_addr] = 1'b1;
        end
      end
      if (m_load && load_valid) begin
        m_mem[m_ptr] = load_data; m_known[m_ptr] = 1'b1;
        if (load_last || m_ptr == 16'hFFFF) m_load = 1'b0;
        m_ptr = m_ptr + 16'd1;
      end
      m_tick = tick_next;
      m_shadow = shadow_next;
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("model_hold", {7'd0, cpu_hold}, {7'd0, m_load});
      check("model_ready", {7'd0, load_ready}, {7'd0, m_load});
      check("model_io_out", io_out, m_io_out);
      if (m_rknown) check("model_rdata", cpu_rdata, m_rdata);
    end
  end

  task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic w);
    cpu_addr = a; cpu_wdata = d; cpu_wren = w;
    @(negedge clock);
    cpu_wren = 1'b0;
  endtask

  task automatic ld(input logic [7:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    @(negedge clock);
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cpu_addr = 16'h0; cpu_wdata = 8'h0; cpu_wren = 1'b0;
    load_valid = 1'b0; load_data = 8'h0; load_last = 1'b0; io_in = 8'h0;
    b_reset = 1'b1; b_addr = 16'h7F00;
    fork
      begin
        @(negedge clock);
        check("rst_hold", {7'd0, cpu_hold}, 8'h01);
        check("rst_ready", {7'd0, load_ready}, 8'h01);
        check("rst_rdata", cpu_rdata, 8'h00);
        check("rst_io_out", io_out, 8'h00);
        reset = 1'b0;
        ld(8'h11, 1'b0); ld(8'h22, 1'b0);
        reset = 1'b1; @(negedge clock); reset = 1'b0;
        ld(8'hA9, 1'b0); ld(8'h01, 1'b0); ld(8'h8D, 1'b0);
        check("hold_before_last", {7'd0, cpu_hold}, 8'h01);
        ld(8'h02, 1'b1);
        check("hold_after_last", {7'd0, cpu_hold}, 8'h00);
        check("ready_after_last", {7'd0, load_ready}, 8'h00);
        load_valid = 1'b1; load_data = 8'h77; cyc(16'h8004, 8'h00, 1'b0); load_valid = 1'b0;
        cyc(16'h8000, 8'h00, 1'b0); check("rom_8000", cpu_rdata, 8'hA9);
        cyc(16'h8001, 8'h00, 1'b0); check("rom_8001", cpu_rdata, 8'h01);
        cyc(16'h8002, 8'h00, 1'b0); check("rom_8002", cpu_rdata, 8'h8D);
        cyc(16'h8003, 8'h00, 1'b0); check("rom_8003", cpu_rdata, 8'h02);
        cyc(16'h0010, 8'h55, 1'b1);
        cyc(16'h0010, 8'h00, 1'b0); check("ram_read", cpu_rdata, 8'h55);
        cyc(16'h0010, 8'hAA, 1'b1); check("ram_rdw_old", cpu_rdata, 8'h55);
        cyc(16'h0010, 8'h00, 1'b0); check("ram_rdw_new", cpu_rdata, 8'hAA);
        cyc(16'h8000, 8'h12, 1'b1);
        cyc(16'h8000, 8'h00, 1'b0); check("rom_protect", cpu_rdata, 8'hA9);
        cyc(16'h7F02, 8'h3C, 1'b1); check("io_out_write", io_out, 8'h3C);
        cyc(16'h7F02, 8'h00, 1'b0); check("io_out_read", cpu_rdata, 8'h3C);
        io_in = 8'h99;
        cyc(16'h7F03, 8'h00, 1'b0); check("io_in_read", cpu_rdata, 8'h99);
        cyc(16'h7F10, 8'h00, 1'b0); check("io_unused", cpu_rdata, 8'h00);
        cyc(16'h7F00, 8'h00, 1'b1);
        repeat (255) cyc(16'h0010, 8'h00, 1'b0);
        cyc(16'h7F00, 8'h00, 1'b0); check("tick_ff", cpu_rdata, 8'hFF);
        cyc(16'h0010, 8'h00, 1'b0); cyc(16'h0010, 8'h00, 1'b0);
        cyc(16'h7F01, 8'h00, 1'b0); check("tick_shadow", cpu_rdata, 8'h00);
        reset = 1'b1; @(negedge clock); reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
          cyc(16'h7F00, 8'h00, 1'b0); check("tick_hold_load", cpu_rdata, 8'h00);
        end
        cpu_addr = 16'h0010;
        for (int i = 0; i < 32768; i++) begin
          if (i == 32767) check("hold_before_full", {7'd0, cpu_hold}, 8'h01);
          ld(8'(i) ^ 8'h5A, 1'b0);
        end
        check("hold_after_full", {7'd0, cpu_hold}, 8'h00);
        check("ready_after_full", {7'd0, load_ready}, 8'h00);
        cyc(16'hFFFF, 8'h00, 1'b0); check("full_ffff", cpu_rdata, 8'hA5);
        cyc(16'h8000, 8'h00, 1'b0); check("full_8000", cpu_rdata, 8'h5A);
        cyc(16'h7F00, 8'h00, 1'b0); check("tick_after_load", cpu_rdata, 8'h02);
      end
      begin
        @(negedge clock);
        check("noload_hold", {7'd0, b_hold}, 8'h00);
        check("noload_ready", {7'd0, b_ready}, 8'h00);
        check("noload_rdata", b_rdata, 8'h00);
        b_reset = 1'b0;
        repeat (65536) @(posedge clock);
        @(negedge clock);
        check("wrap_pre_ff", b_rdata, 8'hFF);
        b_addr = 16'h7F01;
        @(negedge clock);
        check("wrap_shadow_ff", b_rdata, 8'hFF);
        b_addr = 16'h7F00;
        @(negedge clock);
        check("wrap_low_01", b_rdata, 8'h01);
        b_addr = 16'h7F01;
        @(negedge clock);
        check("wrap_shadow_00", b_rdata, 8'h00);
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
